// File: rtl/frame_seq_ctrl_pkg.sv
// frame_seq_ctrl_pkg: state encoding and frame constants shared by the sequencer
package frame_seq_ctrl_pkg;
    typedef enum logic [2:0] {
        S_ID, S_X, S_Y, S_END, S_RD, S_RDW, S_ISSUE, S_WB
    } state_t;
    localparam logic [7:0] FRAME_DELIM = 8'hFF;
    localparam int FRAME_LEN = 4;
endpackage

// File: rtl/frame_seq_ctrl_if.sv
// frame_seq_ctrl_if: UART byte input, position table and speed calculator signals
interface frame_seq_ctrl_if #(parameter int width = 8, depth = 6);
    logic             i_rx_valid;
    logic [width-1:0] i_rx_data;
    logic [depth-1:0] o_tbl_rdaddr;
    logic             o_tbl_rden;
    logic [width-1:0] i_tbl_x;
    logic [width-1:0] i_tbl_y;
    logic             i_tbl_vld;
    logic             o_tbl_wren;
    logic [depth-1:0] o_tbl_wraddr;
    logic [width-1:0] o_tbl_wrx;
    logic [width-1:0] o_tbl_wry;
    logic             o_calc_valid;
    logic             i_calc_ready;
    logic [depth-1:0] o_calc_id;
    logic [width-1:0] o_calc_dx;
    logic [width-1:0] o_calc_dy;
    logic             o_frame_err;
    logic             o_overrun;
    modport master (
        input  i_rx_valid, i_rx_data, i_tbl_x, i_tbl_y, i_tbl_vld, i_calc_ready,
        output o_tbl_rdaddr, o_tbl_rden, o_tbl_wren, o_tbl_wraddr, o_tbl_wrx, o_tbl_wry,
               o_calc_valid, o_calc_id, o_calc_dx, o_calc_dy, o_frame_err, o_overrun
    );
    modport slave (
        output i_rx_valid, i_rx_data, i_tbl_x, i_tbl_y, i_tbl_vld, i_calc_ready,
        input  o_tbl_rdaddr, o_tbl_rden, o_tbl_wren, o_tbl_wraddr, o_tbl_wrx, o_tbl_wry,
               o_calc_valid, o_calc_id, o_calc_dx, o_calc_dy, o_frame_err, o_overrun
    );
endinterface

// File: rtl/frame_seq_ctrl.sv
// frame_seq_ctrl: assembles {id,x,y,FF} frames, updates the position table, offers |dx|,|dy|
module frame_seq_ctrl
    import frame_seq_ctrl_pkg::*;
#(
    parameter int width = 8,
    parameter int depth = 6,
    parameter int timeout = 2000
) (
    input logic clk,
    input logic rst_n,
    frame_seq_ctrl_if.master bus
);
    localparam int tw = $clog2(timeout + 1);
    state_t state, state_d;
    logic [depth-1:0] id_q;
    logic [width-1:0] x_q, y_q, dx_q, dy_q;
    logic [tw-1:0] tmo_q;
    logic err_q, err_d, ovr_q, ovr_d;
    logic rx, delim, bad_id, expired, collecting, busy;

    function automatic logic [width-1:0] abs_diff(input logic [width-1:0] a, input logic [width-1:0] b);
        return a > b ? a - b : b - a;
    endfunction

    assign rx = bus.i_rx_valid;
    assign delim = bus.i_rx_data == width'(FRAME_DELIM);
    assign bad_id = |(bus.i_rx_data >> depth);
    assign expired = tmo_q == tw'(timeout - 1);
    assign collecting = state == S_X || state == S_Y || state == S_END;
    assign busy = state == S_RD || state == S_RDW || state == S_ISSUE || state == S_WB;

    always_comb begin
        state_d = state;
        err_d = 1'b0;
        ovr_d = busy && rx;
        case (state)
            S_ID: begin
                err_d = rx && !delim && bad_id;
                state_d = rx && !delim && !bad_id ? S_X : S_ID;
            end
            S_X, S_Y, S_END: begin
                // An arriving byte beats a coincident timeout expiry
                err_d = rx ? state == S_END && !delim : expired;
                state_d = rx ? (state == S_X ? S_Y : state == S_Y ? S_END : delim ? S_RD : S_ID)
                             : expired ? S_ID : state;
            end
            S_RD: state_d = S_RDW;
            S_RDW: state_d = bus.i_tbl_vld ? S_ISSUE : S_WB;
            S_ISSUE: state_d = bus.i_calc_ready ? S_WB : S_ISSUE;
            default: state_d = S_ID;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_ID;
            id_q <= '0;
            x_q <= '0;
            y_q <= '0;
            dx_q <= '0;
            dy_q <= '0;
            tmo_q <= '0;
            err_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            state <= state_d;
            err_q <= err_d;
            ovr_q <= ovr_d;
            tmo_q <= rx || !collecting ? '0 : tmo_q + tw'(1);
            if (rx && state == S_ID) id_q <= bus.i_rx_data[depth-1:0];
            if (rx && state == S_X) x_q <= bus.i_rx_data;
            if (rx && state == S_Y) y_q <= bus.i_rx_data;
            if (state == S_RDW) begin
                dx_q <= abs_diff(x_q, bus.i_tbl_x);
                dy_q <= abs_diff(y_q, bus.i_tbl_y);
            end
        end
    end

    assign bus.o_tbl_rden = state == S_RD;
    assign bus.o_tbl_rdaddr = id_q;
    assign bus.o_tbl_wren = state == S_WB;
    assign bus.o_tbl_wraddr = id_q;
    assign bus.o_tbl_wrx = x_q;
    assign bus.o_tbl_wry = y_q;
    assign bus.o_calc_valid = state == S_ISSUE;
    assign bus.o_calc_id = id_q;
    assign bus.o_calc_dx = dx_q;
    assign bus.o_calc_dy = dy_q;
    assign bus.o_frame_err = err_q;
    assign bus.o_overrun = ovr_q;
endmodule
